// File: rtl/int_request_controller_if.sv
// Handshake bundle between the interrupt request controller (slave) and the
// peripherals / CPU control unit that drive it (master).
interface int_request_controller_if #(
  parameter int NUM_IRQ = 7,
  parameter int ID_W    = 3
);
  logic [NUM_IRQ-1:0] irq_in;
  logic [NUM_IRQ-1:0] irq_enable;
  logic               sw_int_valid;
  logic [ID_W-1:0]    sw_int_id;
  logic               int_flags_sw_clr;
  logic               if_flag;
  logic               ack_start;
  logic               ack_end;
  logic               int_flag;
  logic [ID_W-1:0]    int_id;
  logic [ID_W-1:0]    current_level;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] in_service;
  logic               protocol_err;

  modport master (
    output irq_in, irq_enable, sw_int_valid, sw_int_id, int_flags_sw_clr,
    output if_flag, ack_start, ack_end,
    input  int_flag, int_id, current_level, pending, in_service, protocol_err
  );

  modport slave (
    input  irq_in, irq_enable, sw_int_valid, sw_int_id, int_flags_sw_clr,
    input  if_flag, ack_start, ack_end,
    output int_flag, int_id, current_level, pending, in_service, protocol_err
  );
endinterface

// File: rtl/int_request_controller.sv
// Interrupt request controller: latches IRQ edges / software requests, arbitrates
// against the in-service level and tracks nesting. INT_CTRL_IRQ_SYNC_EN adds a 2-flop irq_in synchronizer.
module int_request_controller #(
  parameter int NUM_IRQ = 7,
  parameter int ID_W    = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  int_request_controller_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    COMMIT = 2'd2
  } state_t;

  generate
    if ((1 << ID_W) <= NUM_IRQ) begin : g_id_w_check
      $error("int_request_controller: ID_W too narrow to encode NUM_IRQ");
    end
  endgenerate

  state_t             state_q, state_d;
  logic               int_flag_q, int_flag_d;
  logic [ID_W-1:0]    int_id_q, int_id_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] in_service_q, in_service_d;
  logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
  logic               protocol_err_q, protocol_err_d;

  logic [NUM_IRQ-1:0] irq_s;
  logic [NUM_IRQ-1:0] irq_rise;
  logic [NUM_IRQ-1:0] sw_set;
  logic [NUM_IRQ-1:0] above_level;
  logic [NUM_IRQ-1:0] id_match;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] clr_mask;
  logic [NUM_IRQ-1:0] top_service;
  logic [ID_W-1:0]    level;
  logic [ID_W-1:0]    winner_id;
  logic               any_eligible;
  logic               in_commit;
  logic               ack_start_ok;
  logic               ack_end_ok;
  logic               latched_eligible;

`ifdef INT_CTRL_IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync1_d;
  logic [NUM_IRQ-1:0] sync2_q, sync2_d;

  assign sync1_d = bus.irq_in;
  assign sync2_d = sync1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = bus.irq_in;
`endif

  assign irq_prev_d = irq_s;

  // Bit gi of every per-source vector corresponds to interrupt ID gi+1.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_bit
      localparam logic [ID_W-1:0] BIT_ID = ID_W'(gi + 1);
      assign irq_rise[gi]    = irq_s[gi] & ~irq_prev_q[gi];
      assign sw_set[gi]      = bus.sw_int_valid && (bus.sw_int_id == BIT_ID);
      assign above_level[gi] = (BIT_ID > level);
      assign id_match[gi]    = (int_id_q == BIT_ID);
    end
  endgenerate

  // Highest in-service ID, plus a one-hot of that bit for ack_end retirement.
  always_comb begin
    level       = '0;
    top_service = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (in_service_q[i]) begin
        level       = ID_W'(i + 1);
        top_service = '0;
        top_service[i] = 1'b1;
      end
    end
  end

  assign eligible = pending_q & bus.irq_enable & above_level & ~in_service_q;

  always_comb begin
    winner_id    = '0;
    any_eligible = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (eligible[i]) begin
        winner_id    = ID_W'(i + 1);
        any_eligible = 1'b1;
      end
    end
  end

  assign in_commit    = (state_q == COMMIT);
  assign ack_start_ok = bus.ack_start && in_commit;
  assign ack_end_ok   = bus.ack_end && !bus.ack_start && (|in_service_q);

  assign protocol_err_d = (bus.ack_start && !in_commit)
                        || (bus.ack_end && bus.ack_start)
                        || (bus.ack_end && !(|in_service_q));

  // A bulk clear must not drop the ID the CPU is already committing to.
  always_comb begin
    clr_mask = '0;
    if (bus.int_flags_sw_clr) begin
      clr_mask = in_commit ? ~id_match : '1;
    end
    if (ack_start_ok) begin
      clr_mask = clr_mask | id_match;
    end
  end

  assign pending_d = (pending_q & ~clr_mask) | irq_rise | sw_set;

  always_comb begin
    in_service_d = in_service_q;
    if (ack_start_ok) begin
      in_service_d = in_service_q | id_match;
    end else if (ack_end_ok) begin
      in_service_d = in_service_q & ~top_service;
    end
  end

  // The request is withdrawn as soon as next-cycle pending no longer holds it.
  assign latched_eligible = |(id_match & pending_d & bus.irq_enable & above_level);

  always_comb begin
    state_d    = state_q;
    int_flag_d = int_flag_q;
    int_id_d   = int_id_q;
    unique case (state_q)
      IDLE: begin
        int_flag_d = 1'b0;
        if (any_eligible) begin
          state_d    = REQ;
          int_id_d   = winner_id;
          int_flag_d = 1'b1;
        end
      end
      REQ: begin
        int_flag_d = 1'b1;
        if (bus.if_flag) begin
          state_d    = COMMIT;
          int_flag_d = 1'b0;
        end else if (!latched_eligible) begin
          state_d    = IDLE;
          int_flag_d = 1'b0;
        end
      end
      COMMIT: begin
        int_flag_d = 1'b0;
        if (bus.ack_start) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        int_flag_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      int_flag_q     <= 1'b0;
      int_id_q       <= '0;
      pending_q      <= '0;
      in_service_q   <= '0;
      irq_prev_q     <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      int_flag_q     <= int_flag_d;
      int_id_q       <= int_id_d;
      pending_q      <= pending_d;
      in_service_q   <= in_service_d;
      irq_prev_q     <= irq_prev_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  assign bus.int_flag      = int_flag_q;
  assign bus.int_id        = int_id_q;
  assign bus.current_level = level;
  assign bus.pending       = pending_q;
  assign bus.in_service    = in_service_q;
  assign bus.protocol_err  = protocol_err_q;

endmodule
